jcache: RTL and testbench

- Direct-mapped jump cache (branch target buffer) that supplies the PC unit's predicted redirect `do_jcache` and `jcache_pc` for the instruction currently being fetched.
- Looked up combinationally from `current_pc`.
- Trained by the execute stage when a branch or jump resolves.
- Bulk invalidation is a multi-cycle sweep, issued on interrupt entry/return or a context change.

---
 rtl/jcache_pkg.sv | 20 ++
 rtl/jcache_ctr2.sv | 21 ++
 rtl/jcache.sv | 128 ++++++++++++
 tb/tb_jcache.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/jcache_pkg.sv
// Shared definitions for the jump cache: counter encodings, FSM states and
// the PC field widths used to split a fetch address into index and tag.
package jcache_pkg;

    localparam int unsigned JC_PC_W    = 32;
    localparam int unsigned JC_ENTRIES = 16;
    localparam int unsigned JC_IDX_W   = 4;
    localparam int unsigned JC_TAG_W   = JC_PC_W - JC_IDX_W - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        JC_IDLE  = 1'b0,
        JC_SWEEP = 1'b1
    } jc_state_e;

endpackage

// File: rtl/jcache_ctr2.sv
// Two-bit saturating up/down counter next-state function.
module jcache_ctr2
    import jcache_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       up,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (up) begin
            if (ctr != CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else if (ctr != CTR_SNT) begin
            ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/jcache.sv
// Direct-mapped jump cache: combinational lookup from the fetch PC, trained on
// the falling edge by resolved branches, with a multi-cycle invalidate sweep.
module jcache
    import jcache_pkg::*;
#(
    parameter int unsigned ENTRIES = JC_ENTRIES,
    parameter int unsigned IDX_W   = JC_IDX_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic        do_jcache,
    output logic [31:0] jcache_pc,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
    input  logic        invalidate_all,
    output logic        jcache_busy
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    jc_state_e        state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit, upd_en;
    logic [1:0]       upd_ctr;

    // Word-aligned fetch: the byte-offset bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{current_pc[1:0], update_pc[1:0]};

    assign lk_idx  = current_pc[IDX_W+1:2];
    assign lk_tag  = current_pc[31:IDX_W+2];
    assign upd_idx = update_pc[IDX_W+1:2];
    assign upd_tag = update_pc[31:IDX_W+2];

    assign jcache_busy = (state_q == JC_SWEEP);

    always_comb begin
        lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1]
                 && !jcache_busy;
        do_jcache = lk_hit;
        jcache_pc = lk_hit ? target_q[lk_idx] : 32'd0;
    end

    // An invalidate request in the same cycle wins over training.
    always_comb begin
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_en  = update_valid && (state_q == JC_IDLE) && !invalidate_all;
    end

    jcache_ctr2 u_ctr2 (
        .ctr      (ctr_q[upd_idx]),
        .up       (update_taken),
        .ctr_next (upd_ctr)
    );

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        unique case (state_q)
            JC_IDLE: begin
                if (invalidate_all) begin
                    state_d     = JC_SWEEP;
                    sweep_idx_d = '0;
                end
            end
            JC_SWEEP: begin
                if (invalidate_all) begin
                    sweep_idx_d = '0;
                end else if (sweep_idx_q == LAST_IDX) begin
                    state_d     = JC_IDLE;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d     = JC_IDLE;
                sweep_idx_d = '0;
            end
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= JC_IDLE;
            sweep_idx_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_SNT;
            end
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            if (upd_en) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= upd_ctr;
                    if (update_taken) begin
                        target_q[upd_idx] <= update_target;
                    end
                end else if (update_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= update_target;
                    ctr_q[upd_idx]    <= CTR_WT;
                end
            end
            if (state_q == JC_SWEEP) begin
                valid_q[sweep_idx_q] <= 1'b0;
                ctr_q[sweep_idx_q]   <= CTR_SNT;
            end
        end
    end

endmodule

// File: tb/tb_jcache.sv
// Directed self-checking bench for the jump cache.
module tb_jcache;

    logic        clock = 1'b1;
    logic        reset;
    logic [31:0] current_pc;
    logic        do_jcache;
    logic [31:0] jcache_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        invalidate_all;
    logic        jcache_busy;

    int checks   = 0;
    int failures = 0;

    jcache dut (
        .clock          (clock),
        .reset          (reset),
        .current_pc     (current_pc),
        .do_jcache      (do_jcache),
        .jcache_pc      (jcache_pc),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_target  (update_target),
        .update_taken   (update_taken),
        .invalidate_all (invalidate_all),
        .jcache_busy    (jcache_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic edge_wait();
        @(negedge clock);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_target = tgt;
        update_taken  = taken;
        edge_wait();
        update_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic [31:0] tgt);
        current_pc = pc;
        #1;
        check({tag, "_hit"}, {31'd0, do_jcache}, {31'd0, hit});
        check({tag, "_pc"}, jcache_pc, hit ? tgt : 32'd0);
    endtask

    int cnt;

    initial begin
        reset          = 1'b1;
        current_pc     = 32'h100;
        update_valid   = 1'b0;
        update_pc      = '0;
        update_target  = '0;
        update_taken   = 1'b0;
        invalidate_all = 1'b0;
        #2;
        look("rst_in", 32'h100, 1'b0, 32'h0);
        check("rst_busy", {31'd0, jcache_busy}, 32'd0);
        #5 reset = 1'b0;
        edge_wait();
        look("post_rst", 32'h100, 1'b0, 32'h0);
        check("post_rst_busy", {31'd0, jcache_busy}, 32'd0);

        // Allocation with ctr=10, then counter walk incl. saturation at 11.
        do_update(32'h100, 32'h40, 1'b1);
        look("alloc", 32'h100, 1'b1, 32'h40);
        look("alias_miss", 32'h140, 1'b0, 32'h0);
        do_update(32'h100, 32'h40, 1'b0);
        look("ctr01", 32'h100, 1'b0, 32'h0);
        do_update(32'h100, 32'h40, 1'b1);
        look("ctr10", 32'h100, 1'b1, 32'h40);
        do_update(32'h100, 32'h40, 1'b1);
        look("ctr11", 32'h100, 1'b1, 32'h40);
        do_update(32'h100, 32'h40, 1'b0);
        look("ctr11_nt", 32'h100, 1'b1, 32'h40);
        do_update(32'h100, 32'h40, 1'b1);
        do_update(32'h100, 32'h48, 1'b1);
        look("sat_tgt", 32'h100, 1'b1, 32'h48);
        do_update(32'h100, 32'h0, 1'b0);
        look("sat_nt1", 32'h100, 1'b1, 32'h48);
        do_update(32'h100, 32'h0, 1'b0);
        look("sat_nt2", 32'h100, 1'b0, 32'h0);

        // Tag conflict overwrite; not-taken miss leaves the entry alone.
        do_update(32'h140, 32'h80, 1'b1);
        look("old_tag", 32'h100, 1'b0, 32'h0);
        look("new_tag", 32'h140, 1'b1, 32'h80);
        look("lowbits", 32'h143, 1'b1, 32'h80);
        do_update(32'h200, 32'h77, 1'b0);
        look("nt_miss_keep", 32'h140, 1'b1, 32'h80);
        look("nt_miss_none", 32'h200, 1'b0, 32'h0);
        do_update(32'h140, 32'h0, 1'b0);
        look("conf_ctr10", 32'h140, 1'b0, 32'h0);

        // Read-during-write: old contents this cycle, new after the edge.
        current_pc    = 32'h304;
        update_valid  = 1'b1;
        update_pc     = 32'h304;
        update_target = 32'h99;
        update_taken  = 1'b1;
        look("rdw_old", 32'h304, 1'b0, 32'h0);
        edge_wait();
        update_valid = 1'b0;
        look("rdw_new", 32'h304, 1'b1, 32'h99);

        // Fill, then sweep with a simultaneous and a mid-sweep update.
        for (int i = 0; i < 16; i++) begin
            do_update(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), 1'b1);
        end
        look("fill0", 32'h1000, 1'b1, 32'h2000);
        look("fill15", 32'h103c, 1'b1, 32'h200f);
        invalidate_all = 1'b1;
        update_valid   = 1'b1;
        update_pc      = 32'h6010;
        update_target  = 32'h55;
        update_taken   = 1'b1;
        edge_wait();
        invalidate_all = 1'b0;
        update_valid   = 1'b0;
        cnt = 0;
        while (jcache_busy && cnt < 40) begin
            if (cnt == 3) begin
                update_valid  = 1'b1;
                update_pc     = 32'h5000;
                update_target = 32'h66;
                update_taken  = 1'b1;
            end
            if (cnt == 5) look("sweep_miss", 32'h103c, 1'b0, 32'h0);
            cnt++;
            edge_wait();
            update_valid = 1'b0;
        end
        check("sweep_len", 32'(cnt), 32'd16);
        for (int i = 0; i < 16; i++) begin
            current_pc = 32'h1000 + 32'(i * 4);
            #0.1;
            check("post_sweep", {31'd0, do_jcache}, 32'd0);
        end
        look("drop_simul", 32'h6010, 1'b0, 32'h0);
        look("drop_mid", 32'h5000, 1'b0, 32'h0);

        // Reset in the middle of a sweep.
        do_update(32'h1028, 32'h3000, 1'b1);
        invalidate_all = 1'b1;
        edge_wait();
        invalidate_all = 1'b0;
        for (int i = 0; i < 5; i++) edge_wait();
        check("busy_mid", {31'd0, jcache_busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_busy_now", {31'd0, jcache_busy}, 32'd0);
        reset = 1'b0;
        edge_wait();
        check("rst_busy_after", {31'd0, jcache_busy}, 32'd0);
        look("rst_cleared", 32'h1028, 1'b0, 32'h0);
        do_update(32'h1028, 32'h3004, 1'b1);
        look("rst_idle_upd", 32'h1028, 1'b1, 32'h3004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
